// File: rtl/johnson_seq_ctrl.sv
// rtl/johnson_seq_ctrl.sv - command-driven Johnson counter sequencer
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command offered
//   cmd_ready  command accepted when cmd_valid && cmd_ready at a clk edge
//   cmd_op     00 RUN, 01 STOP, 10 STEP, 11 CLEAR
//   cmd_dir    0 = shift left, 1 = shift right (latched on RUN/STEP accept)
//   cmd_count  RUN advance count, 0 = free-run
//   cmd_pre    prescale value, used only with JOHNSON_SEQ_PRESCALE_EN
//   jc_q       Johnson counter state
//   busy       high while in RUN
//   step       one-cycle pulse aligned with each new jc_q value
//   done       one-cycle pulse with the step of the final counted advance
//
// Optional feature: define JOHNSON_SEQ_PRESCALE_EN to add a 4-bit prescaler
// so a RUN advances once every (cmd_pre + 1) edges.
module johnson_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [7:0]       cmd_count,
  input  logic [3:0]       cmd_pre,
  output logic [WIDTH-1:0] jc_q,
  output logic             busy,
  output logic             step,
  output logic             done
);

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] jc_nxt;
  logic [7:0]       remaining, remaining_nxt;
  logic             dir_q, dir_nxt;
  logic             step_nxt, done_nxt;
  logic             accept;
  logic             run_accept;
  logic             tick_hit;

  function automatic logic [WIDTH-1:0] johnson_adv(input logic [WIDTH-1:0] q,
                                                   input logic right);
    if (right) return {~q[0], q[WIDTH-1:1]};
    else       return {q[WIDTH-2:0], ~q[WIDTH-1]};
  endfunction

  // While running, only STOP and CLEAR can get in; RUN/STEP are refused.
  assign cmd_ready = (state == IDLE) || (cmd_op == OP_STOP) || (cmd_op == OP_CLEAR);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state == RUN);

`ifdef JOHNSON_SEQ_PRESCALE_EN
  logic [3:0] tick;
  logic [3:0] pre_q;

  // Tick restarts at each RUN accept so the first advance lands P+1 edges later.
  assign tick_hit = (tick == pre_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick  <= 4'd0;
      pre_q <= 4'd0;
    end else if (run_accept) begin
      tick  <= 4'd0;
      pre_q <= cmd_pre;
    end else if (state == RUN) begin
      tick  <= tick_hit ? 4'd0 : tick + 4'd1;
    end
  end
`else
  logic unused_pre;
  assign unused_pre = ^cmd_pre;
  assign tick_hit   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      jc_q      <= '0;
      remaining <= 8'd0;
      dir_q     <= 1'b0;
      step      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      jc_q      <= jc_nxt;
      remaining <= remaining_nxt;
      dir_q     <= dir_nxt;
      step      <= step_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    jc_nxt        = jc_q;
    remaining_nxt = remaining;
    dir_nxt       = dir_q;
    step_nxt      = 1'b0;
    done_nxt      = 1'b0;
    run_accept    = 1'b0;

    // STOP/CLEAR are checked first so they beat a coincident advance.
    if (accept && cmd_op == OP_CLEAR) begin
      jc_nxt        = '0;
      remaining_nxt = 8'd0;
      state_nxt     = IDLE;
    end else if (accept && cmd_op == OP_STOP) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && cmd_op == OP_RUN) begin
            run_accept    = 1'b1;
            dir_nxt       = cmd_dir;
            remaining_nxt = cmd_count;
            state_nxt     = RUN;
          end else if (accept && cmd_op == OP_STEP) begin
            dir_nxt  = cmd_dir;
            jc_nxt   = johnson_adv(jc_q, cmd_dir);
            step_nxt = 1'b1;
          end
        end
        RUN: begin
          if (tick_hit) begin
            jc_nxt   = johnson_adv(jc_q, dir_q);
            step_nxt = 1'b1;
            // remaining == 0 means free-run; a counted run leaves on its last advance.
            if (remaining == 8'd1) begin
              remaining_nxt = 8'd0;
              done_nxt      = 1'b1;
              state_nxt     = IDLE;
            end else if (remaining != 8'd0) begin
              remaining_nxt = remaining - 8'd1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb/tb_johnson_seq_ctrl.sv - self-checking bench for johnson_seq_ctrl (WIDTH = 8)
module tb_johnson_seq_ctrl;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
`ifdef JOHNSON_SEQ_PRESCALE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = OP_RUN;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_count = 8'd0;
  logic [3:0] cmd_pre = 4'd0;
  logic [7:0] jc_q;
  logic       busy, step, done;

  int checks = 0;
  int errors = 0;

  johnson_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_pre(cmd_pre),
    .jc_q(jc_q), .busy(busy), .step(step), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: a Johnson counter of width 8 is a position on a 16-step ring.
  // Position p <= 8 means the low p bits are ones; p > 8 means the top
  // (16 - p) bits are ones.
  function automatic logic [7:0] pos2jc(input int p);
    logic [15:0] v;
    if (p <= 8) v = (16'h1 << p) - 16'h1;
    else        v = 16'h00FF << (p - 8);
    return v[7:0];
  endfunction

  int  m_pos = 0;
  bit  m_busy = 0;
  int  m_left = 0;   // advances still owed, -1 = free-run
  int  m_cnt = 0;    // edges since RUN accept
  int  m_pre = 0;
  bit  m_dir = 0;
  bit  m_step = 0;
  bit  m_done = 0;
  bit  m_live = 0;
  bit  m_acc;

  function automatic int move(input int p, input bit right);
    return right ? (p + 15) % 16 : (p + 1) % 16;
  endfunction

  always @(posedge clk) begin
    m_step = 0;
    m_done = 0;
    if (rst) begin
      m_pos = 0; m_busy = 0; m_left = 0; m_cnt = 0; m_live = 1;
    end else begin
      m_acc = cmd_valid && (!m_busy || cmd_op == OP_STOP || cmd_op == OP_CLEAR);
      if (m_acc && cmd_op == OP_CLEAR) begin
        m_pos = 0; m_busy = 0; m_left = 0;
      end else if (m_acc && cmd_op == OP_STOP) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (m_acc && cmd_op == OP_RUN) begin
          m_busy = 1;
          m_dir  = cmd_dir;
          m_left = (cmd_count == 0) ? -1 : int'(cmd_count);
          m_cnt  = 0;
          m_pre  = PRE_EN ? int'(cmd_pre) : 0;
        end else if (m_acc && cmd_op == OP_STEP) begin
          m_pos  = move(m_pos, cmd_dir);
          m_step = 1;
        end
      end else begin
        m_cnt++;
        if (m_cnt % (m_pre + 1) == 0) begin
          m_pos  = move(m_pos, m_dir);
          m_step = 1;
          if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
              m_done = 1;
              m_busy = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_jc",    jc_q,  pos2jc(m_pos));
      chk("model_busy",  busy,  m_busy);
      chk("model_step",  step,  m_step);
      chk("model_done",  done,  m_done);
      chk("model_ready", cmd_ready,
          (!m_busy || cmd_op == OP_STOP || cmd_op == OP_CLEAR));
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic dir, input logic [7:0] cnt,
                      input logic [3:0] pre);
    cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_count = cnt; cmd_pre = pre;
    tick(1);
    cmd_valid = 1'b0; cmd_op = OP_RUN;
  endtask

  initial begin
    // Reset held two cycles.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rst_jc", jc_q, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_step", step, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("pin_model_pos2jc_9", pos2jc(9), 8'hFE);
    chk("pin_model_pos2jc_15", pos2jc(15), 8'h80);

    // RUN left count 3: 01, 03, 07 then done.
    send(OP_RUN, 1'b0, 8'd3, 4'd0);
    chk("run3_accept_noadv", jc_q, 8'h00);
    chk("run3_busy", busy, 1'b1);
    tick(1); chk("run3_a1", jc_q, 8'h01);
    tick(1); chk("run3_a2", jc_q, 8'h03);
    tick(1); chk("run3_a3", jc_q, 8'h07);
    chk("run3_done", done, 1'b1);
    chk("run3_step", step, 1'b1);
    tick(1); chk("run3_busy_after", busy, 1'b0);
    chk("run3_hold", jc_q, 8'h07);

    // Full ring left, then one right step from zero.
    send(OP_CLEAR, 1'b0, 8'd0, 4'd0);
    chk("clear_jc", jc_q, 8'h00);
    send(OP_RUN, 1'b0, 8'd16, 4'd0);
    tick(8);  chk("ring_l_8", jc_q, 8'hFF);
    tick(1);  chk("ring_l_9", jc_q, 8'hFE);
    chk("ring_l_nodone", done, 1'b0);
    tick(7);  chk("ring_l_16", jc_q, 8'h00);
    chk("ring_l_done", done, 1'b1);
    send(OP_RUN, 1'b1, 8'd1, 4'd0);
    tick(1);  chk("run_r1", jc_q, 8'h80);
    chk("run_r1_done", done, 1'b1);

    // Full ring right returns to zero.
    send(OP_CLEAR, 1'b0, 8'd0, 4'd0);
    send(OP_RUN, 1'b1, 8'd16, 4'd0);
    tick(8);  chk("ring_r_8", jc_q, 8'hFF);
    tick(8);  chk("ring_r_16", jc_q, 8'h00);

    // Free-run stopped on the 6th edge after accept.
    send(OP_CLEAR, 1'b0, 8'd0, 4'd0);
    send(OP_RUN, 1'b0, 8'd0, 4'd0);
    tick(5);  chk("free_5", jc_q, 8'h1F);
    send(OP_STOP, 1'b0, 8'd0, 4'd0);
    chk("stop_jc", jc_q, 8'h1F);
    chk("stop_busy", busy, 1'b0);
    chk("stop_done", done, 1'b0);
    tick(3);  chk("stop_hold", jc_q, 8'h1F);
    send(OP_STOP, 1'b0, 8'd0, 4'd0);
    chk("stop_idle_noop", jc_q, 8'h1F);

    // Prescale 2, count 2.
    send(OP_CLEAR, 1'b0, 8'd0, 4'd0);
    send(OP_RUN, 1'b0, 8'd2, 4'd2);
    if (PRE_EN) begin
      tick(2); chk("pre_k2", jc_q, 8'h00);
      tick(1); chk("pre_k3", jc_q, 8'h01);
      tick(3); chk("pre_k6", jc_q, 8'h03);
      chk("pre_done", done, 1'b1);
    end else begin
      tick(1); chk("nopre_k1", jc_q, 8'h01);
      tick(1); chk("nopre_k2", jc_q, 8'h03);
      chk("nopre_done", done, 1'b1);
    end

    // STEP in idle, both directions.
    send(OP_CLEAR, 1'b0, 8'd0, 4'd0);
    send(OP_STEP, 1'b0, 8'd0, 4'd0);
    chk("step_l", jc_q, 8'h01);
    chk("step_l_pulse", step, 1'b1);
    chk("step_l_busy", busy, 1'b0);
    chk("step_l_done", done, 1'b0);
    send(OP_STEP, 1'b1, 8'd0, 4'd0);
    chk("step_r", jc_q, 8'h00);

    // Commands during RUN: RUN refused, CLEAR accepted.
    send(OP_RUN, 1'b0, 8'd0, 4'd0);
    tick(2);  chk("mid_run_2", jc_q, 8'h03);
    cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_dir = 1'b1; cmd_count = 8'd1;
    #1;
    chk("mid_run_ready", cmd_ready, 1'b0);
    tick(1);  chk("mid_run_unaffected", jc_q, 8'h07);
    cmd_op = OP_CLEAR;
    #1;
    chk("mid_clear_ready", cmd_ready, 1'b1);
    tick(1);
    cmd_valid = 1'b0; cmd_op = OP_RUN;
    chk("mid_clear_jc", jc_q, 8'h00);
    chk("mid_clear_busy", busy, 1'b0);
    chk("mid_clear_done", done, 1'b0);
    chk("mid_clear_step", step, 1'b0);

    // Reset mid-RUN overrides a pending command.
    send(OP_RUN, 1'b0, 8'd0, 4'd0);
    tick(3);
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = OP_RUN;
    tick(1);
    rst = 1'b0; cmd_valid = 1'b0;
    chk("rst_mid_jc", jc_q, 8'h00);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_step", step, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_ready", cmd_ready, 1'b1);
    tick(2);
    chk("rst_mid_hold", jc_q, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
